id_branch_redirect: RTL

- Fetch-side consumer of the ID-stage branch decision.
- Owns the PC register and the IF/ID pipeline register.
- Stalls the ID stage while a branch or jr operand is still in flight from EX/MEM.
- Once operands are ready, takes the branch-compare result plus jump decode and redirects fetch: computes the target, loads the PC, and squashes the wrong-path instruction in IF.

---
 rtl/id_branch_redirect.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/id_branch_redirect.sv
`timescale 1ns/1ps
// id_branch_redirect: owns the fetch PC and IF/ID register. It holds ID while branch/jr operands
// are still in flight, then redirects fetch. Define BRANCH_DELAY_SLOT_EN to keep the delay slot.
module id_branch_redirect #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] im_instr,
    input  logic        ext_stall,
    input  logic        id_br_op,
    input  logic        id_branch,
    input  logic        id_jump,
    input  logic        id_jr,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [31:0] id_jr_target,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        mem_memread,
    input  logic [4:0]  mem_rd,
    output logic [31:0] o_pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        o_stall,
    output logic        o_idex_bubble,
    output logic        o_redirect
);

    typedef enum logic {
        ST_RUN,
        ST_STALL
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic        stall, bubble, redirect;
    logic        hazard_eval, ex_hit, mem_hit;
    logic [1:0]  need;
    logic [31:0] seq_pc, br_target, j_target, redir_target;
    logic        redir_cond;

    // Register 0 is hardwired to zero, so a write to it can never be a hazard.
    function automatic logic reads_reg(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic use_rt);
        return (rd != 5'd0) && ((rd == rs) || (use_rt && (rd == rt)));
    endfunction

    // NOTE: every signal driven from always_comb gets a default first, so no path infers a latch.
    always_comb begin
        hazard_eval = (state_q == ST_RUN) && if_id_valid_q && (id_br_op || id_jr);
        ex_hit      = reads_reg(ex_rd, id_rs, id_rt, id_br_op);
        mem_hit     = reads_reg(mem_rd, id_rs, id_rt, id_br_op);
        need        = 2'd0;
        if (hazard_eval) begin
            if (ex_memread && ex_hit) begin
                need = 2'd2;
            end else if ((ex_regwrite && ex_hit) || (mem_memread && mem_hit)) begin
                need = 2'd1;
            end
        end
    end

    assign seq_pc     = if_id_pc_q + 32'd4;
    assign br_target  = seq_pc + {{14{if_id_instr_q[15]}}, if_id_instr_q[15:0], 2'b00};
    assign j_target   = {seq_pc[31:28], if_id_instr_q[25:0], 2'b00};
    assign redir_cond = if_id_valid_q && ((id_br_op && id_branch) || id_jump || id_jr);

    always_comb begin
        if (id_jr) begin
            redir_target = id_jr_target;
        end else if (id_jump) begin
            redir_target = j_target;
        end else begin
            redir_target = br_target;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        stall         = 1'b0;
        bubble        = 1'b0;
        redirect      = 1'b0;
        unique case (state_q)
            ST_STALL: begin
                // Hazard inputs are deliberately ignored here; the counter alone ends the stall.
                stall  = 1'b1;
                bubble = 1'b1;
                if (cnt_q > 2'd1) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    cnt_d   = 2'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ext_stall) begin
                    stall = 1'b1;
                end else if (need != 2'd0) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    cnt_d  = need - 2'd1;
                    if (need == 2'd2) begin
                        state_d = ST_STALL;
                    end
                end else if (redir_cond) begin
                    redirect   = 1'b1;
                    pc_d       = redir_target;
                    if_id_pc_d = pc_q;
`ifdef BRANCH_DELAY_SLOT_EN
                    if_id_instr_d = im_instr;
                    if_id_valid_d = 1'b1;
`else
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
`endif
                end else begin
                    pc_d          = pc_q + 32'd4;
                    if_id_pc_d    = pc_q;
                    if_id_instr_d = im_instr;
                    if_id_valid_d = 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_RUN;
            cnt_q         <= 2'd0;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 32'h0000_0000;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign o_pc          = pc_q;
    assign if_id_pc      = if_id_pc_q;
    assign if_id_instr   = if_id_instr_q;
    assign if_id_valid   = if_id_valid_q;
    // Control outputs are quiet while reset is held, whatever ext_stall is doing.
    assign o_stall       = rstn && stall;
    assign o_idex_bubble = rstn && bubble;
    assign o_redirect    = rstn && redirect;

    a_stall_cnt_one: assert property (@(posedge clk) disable iff (!rstn)
        (state_q == ST_STALL) |-> (cnt_q == 2'd1));
    a_redirect_not_stalled: assert property (@(posedge clk) disable iff (!rstn)
        !(o_redirect && o_stall));

endmodule
